// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO controller that fronts the 16x8 RAM.
package fifo_pkg;

  localparam int ADDR_W        = 4;
  localparam int DEPTH         = 16;
  localparam int AF_THRESH_DEF = 12;
  localparam int AE_THRESH_DEF = 4;

  // Pointer carries one extra wrap bit above the RAM address bits.
  typedef logic [ADDR_W:0]   ptr_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // RAM address portion of a wrap-bit pointer.
  function automatic addr_t ptr_addr(input ptr_t p);
    return p[ADDR_W-1:0];
  endfunction

  // Wrap bit of a pointer.
  function automatic logic ptr_wrap(input ptr_t p);
    return p[ADDR_W];
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Client/RAM-side signal bundle of the FIFO controller.
interface fifo_if;
  import fifo_pkg::*;

  logic  push;
  logic  pop;
  logic  ram_write;
  logic  ram_read;
  addr_t wr_addr;
  addr_t rd_addr;
  logic  rd_valid;
  logic  full;
  logic  empty;
  logic  almost_full;
  logic  almost_empty;
  ptr_t  count;
  logic  overflow;
  logic  underflow;

  // Client side: issues requests, observes strobes and status.
  modport master (
    output push, pop,
    input  ram_write, ram_read, wr_addr, rd_addr, rd_valid,
    input  full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // Controller side.
  modport slave (
    input  push, pop,
    output ram_write, ram_read, wr_addr, rd_addr, rd_valid,
    output full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer register: increments on enable, wraps from the top
// address back to 0 while toggling the wrap bit (natural binary overflow).
module fifo_ptr
  import fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  output ptr_t ptr_o
);

  ptr_t ptr_q;
  ptr_t ptr_d;

  // Next pointer value: advance by one when enabled.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + ptr_t'(1'b1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= ptr_t'(1'b0);
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO controller: converts push/pop into RAM strobes and addresses, tracks
// occupancy with wrap-bit pointers and reports status and sticky errors.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int AF_THRESH = AF_THRESH_DEF,
  parameter int AE_THRESH = AE_THRESH_DEF
)
(
  input  logic   clk,
  input  logic   rst,
  fifo_if.slave  bus
);

  localparam ptr_t AF_T = ptr_t'(AF_THRESH);
  localparam ptr_t AE_T = ptr_t'(AE_THRESH);

  ptr_t wr_ptr_s;
  ptr_t rd_ptr_s;
  ptr_t count_s;
  logic full_s;
  logic empty_s;
  logic wr_acc_s;
  logic rd_acc_s;

  logic rd_valid_q, rd_valid_d;
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  fifo_ptr u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_acc_s),
    .ptr_o (wr_ptr_s)
  );

  fifo_ptr u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_acc_s),
    .ptr_o (rd_ptr_s)
  );

  // Occupancy, flags and acceptance; strobes are held low during reset so
  // no access reaches the RAM while contents are being discarded.
  always_comb begin
    full_s   = (ptr_addr(wr_ptr_s) == ptr_addr(rd_ptr_s)) &&
               (ptr_wrap(wr_ptr_s) != ptr_wrap(rd_ptr_s));
    empty_s  = (wr_ptr_s == rd_ptr_s);
    count_s  = wr_ptr_s - rd_ptr_s;
    rd_acc_s = rst & bus.pop & ~empty_s;
    wr_acc_s = rst & bus.push & (~full_s | rd_acc_s);
  end

  // Next state of read-valid and sticky error bits.
  always_comb begin
    rd_valid_d  = rd_acc_s;
    overflow_d  = overflow_q  | (bus.push & ~wr_acc_s);
    underflow_d = underflow_q | (bus.pop  & ~rd_acc_s);
  end

  // Status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.ram_write    = wr_acc_s;
  assign bus.ram_read     = rd_acc_s;
  assign bus.wr_addr      = ptr_addr(wr_ptr_s);
  assign bus.rd_addr      = ptr_addr(rd_ptr_s);
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_s >= AF_T);
  assign bus.almost_empty = (count_s <= AE_T);
  assign bus.count        = count_s;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Scoreboard bench for fifo_ctrl with a behavioural 16x8 registered-read RAM.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [7:0] ram_dout;
  logic [7:0] mem [16];
  logic [7:0] exp_d;

  int n_checks;
  int n_err;

  // Reference FIFO model state
  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  int m_cnt, m_wr, m_rd;
  logic m_ovf, m_udf, last_r;

  fifo_if bus_if();

  fifo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM driven by the controller strobes
  always @(posedge clk) begin
    if (bus_if.ram_write === 1'b1) mem[bus_if.wr_addr] <= din;
    if (bus_if.ram_read === 1'b1) ram_dout <= mem[bus_if.rd_addr];
  end

  // Monitor: each rd_valid consumes one expected data word
  always @(negedge clk) begin
    if (bus_if.rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: rd_valid with no pop pending, data=%0h", ram_dout);
      end else begin
        exp_d = exp_q.pop_front();
        if (ram_dout !== exp_d) begin
          n_err++;
          $display("FAIL rd_data: got %0h expected %0h", ram_dout, exp_d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", 32'(bus_if.count), m_cnt);
    chk("full", 32'(bus_if.full), 32'(m_cnt == 16));
    chk("empty", 32'(bus_if.empty), 32'(m_cnt == 0));
    chk("almost_full", 32'(bus_if.almost_full), 32'(m_cnt >= 12));
    chk("almost_empty", 32'(bus_if.almost_empty), 32'(m_cnt <= 4));
    chk("overflow", 32'(bus_if.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus_if.underflow), 32'(m_udf));
    chk("wr_addr", 32'(bus_if.wr_addr), m_wr);
    chk("rd_addr", 32'(bus_if.rd_addr), m_rd);
    chk("rd_valid", 32'(bus_if.rd_valid), 32'(last_r));
  endtask

  // One clock of stimulus; strobes checked mid-cycle, state after the edge
  task automatic step(input logic p, input logic q, input logic [7:0] d);
    logic exp_w, exp_r;
    @(negedge clk);
    bus_if.push = p;
    bus_if.pop  = q;
    din         = d;
    exp_r = q && (m_cnt != 0);
    exp_w = p && ((m_cnt != 16) || exp_r);
    #1;
    chk("ram_write", 32'(bus_if.ram_write), 32'(exp_w));
    chk("ram_read", 32'(bus_if.ram_read), 32'(exp_r));
    if (exp_r) begin
      exp_q.push_back(model_q.pop_front());
      m_rd = (m_rd + 1) % 16;
    end
    if (exp_w) begin
      model_q.push_back(d);
      m_wr = (m_wr + 1) % 16;
    end
    m_cnt = m_cnt + int'(exp_w) - int'(exp_r);
    if (p && !exp_w) m_ovf = 1'b1;
    if (q && !exp_r) m_udf = 1'b1;
    last_r = exp_r;
    @(posedge clk);
    #1;
    check_state();
  endtask

  // One reset cycle with the given request levels applied
  task automatic do_reset(input logic p, input logic q);
    @(negedge clk);
    rst = 1'b0;
    bus_if.push = p;
    bus_if.pop  = q;
    #1;
    chk("rst ram_write", 32'(bus_if.ram_write), 32'd0);
    chk("rst ram_read", 32'(bus_if.ram_read), 32'd0);
    @(posedge clk);
    #1;
    m_cnt = 0; m_wr = 0; m_rd = 0;
    m_ovf = 1'b0; m_udf = 1'b0; last_r = 1'b0;
    model_q.delete();
    check_state();
    @(negedge clk);
    rst = 1'b1;
    bus_if.push = 1'b0;
    bus_if.pop  = 1'b0;
  endtask

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0; n_err = 0;
    rst = 1'b0; bus_if.push = 1'b0; bus_if.pop = 1'b0; din = 8'h00;
    m_cnt = 0; m_wr = 0; m_rd = 0; m_ovf = 1'b0; m_udf = 1'b0; last_r = 1'b0;

    do_reset(1'b1, 1'b1);

    // Fill: 16 pushes, almost_full appears at the 12th
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'hA0 + 8'(i));
      if (i == 10) chk("af_before_12", 32'(bus_if.almost_full), 32'd0);
      if (i == 11) chk("af_at_12", 32'(bus_if.almost_full), 32'd1);
    end
    chk("count_full16", 32'(bus_if.count), 32'd16);
    chk("wr_addr_wrapped", 32'(bus_if.wr_addr), 32'd0);
    step(1'b1, 1'b0, 8'hEE);
    chk("overflow_17th", 32'(bus_if.overflow), 32'd1);

    // Drain: 16 back-to-back pops, then a rejected 17th
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    chk("empty_after_drain", 32'(bus_if.empty), 32'd1);
    step(1'b0, 1'b1, 8'h00);
    chk("underflow_17th", 32'(bus_if.underflow), 32'd1);

    // Push+pop while full returns the old entry
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'hB0 + 8'(i));
    step(1'b1, 1'b1, 8'hC0);
    chk("full_pushpop_count", 32'(bus_if.count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

    // Push+pop while empty: pop rejected, push accepted
    step(1'b1, 1'b1, 8'hD0);
    chk("empty_pushpop_count", 32'(bus_if.count), 32'd1);
    chk("empty_pushpop_udf", 32'(bus_if.underflow), 32'd1);
    chk("empty_pushpop_rdv", 32'(bus_if.rd_valid), 32'd0);

    // Pointer wrap with occupancy held at 3
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'h40 + 8'(i));
    chk("wrap_count", 32'(bus_if.count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

    // Reset mid-operation at count 9 with pop high
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'h60 + 8'(i));
    chk("pre_reset_count", 32'(bus_if.count), 32'd9);
    do_reset(1'b0, 1'b1);
    chk("post_reset_count", 32'(bus_if.count), 32'd0);

    // Short sanity run after reset
    step(1'b1, 1'b0, 8'h77);
    step(1'b1, 1'b1, 8'h78);
    step(1'b0, 1'b1, 8'h00);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
